// File: rtl/branch_pkg.sv
// Shared types and opcode constants for the branch-resolution controller.
// Record types are sized by PC_W; the controller's PCW must match it.
package branch_pkg;
    localparam int PC_W = 16;

    localparam logic [3:0] JUMPL  = 4'b0111;
    localparam logic [3:0] JUMPG  = 4'b1000;
    localparam logic [3:0] JUMPE  = 4'b1001;
    localparam logic [3:0] JUMPNE = 4'b1010;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } br_state_e;

    typedef struct packed {
        logic            valid;
        logic            pred;
        logic [PC_W-1:0] target;
    } pred_rec_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic            taken;
    } btb_upd_t;

    function automatic logic is_cond_op(input logic [3:0] op);
        return (op == JUMPL) || (op == JUMPG) || (op == JUMPE) || (op == JUMPNE);
    endfunction
endpackage

// File: rtl/branch_ctrl_if.sv
// Pipeline-facing bus of branch_ctrl: fetch/execute inputs, flush/redirect, BTB update port.
// slave = the controller, master = the pipeline/BTB side driving it.
interface branch_ctrl_if #(parameter int PCW = 16);
    logic           stall;
    logic           fetch_valid;
    logic           btb_prediction;
    logic [PCW-1:0] btb_target;
    logic           ex_valid;
    logic [PCW-1:0] ex_pc;
    logic [3:0]     ex_opcode;
    logic [PCW-1:0] ex_target;
    logic           lflag;
    logic           gflag;
    logic           zflag;
    logic           flush;
    logic [PCW-1:0] redirect_pc;
    logic           upd_valid;
    logic           upd_ready;
    logic [PCW-1:0] upd_pc;
    logic [PCW-1:0] upd_target;
    logic           upd_taken;
    logic [15:0]    mispredict_cnt;
    logic [7:0]     drop_cnt;

    modport slave (
        input  stall, fetch_valid, btb_prediction, btb_target,
        input  ex_valid, ex_pc, ex_opcode, ex_target, lflag, gflag, zflag,
        input  upd_ready,
        output flush, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken,
        output mispredict_cnt, drop_cnt
    );

    modport master (
        output stall, fetch_valid, btb_prediction, btb_target,
        output ex_valid, ex_pc, ex_opcode, ex_target, lflag, gflag, zflag,
        output upd_ready,
        input  flush, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken,
        input  mispredict_cnt, drop_cnt
    );
endinterface

// File: rtl/btb_upd_fifo.sv
// BTB training-update FIFO; a push is visible on head_o one cycle later.
// Full without a simultaneous pop drops the push and bumps a saturating drop counter.
module btb_upd_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_i,
    input  btb_upd_t push_dat_i,
    input  logic     pop_i,
    output btb_upd_t head_o,
    output logic     empty_o,
    output logic     full_o,
    output logic [7:0] drop_cnt_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    btb_upd_t      mem_q [DEPTH];
    btb_upd_t      last_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic [7:0]    drop_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the slot in the same cycle, so a push into a full queue still lands.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            drop_q   <= '0;
            last_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (push_i && !do_push && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    // The last popped entry stays visible while empty so the port never shows stale slots.
    assign head_o     = empty_o ? last_q : mem_q[rd_ptr_q];
    assign drop_cnt_o = drop_q;
endmodule

// File: rtl/branch_ctrl.sv
// Tracks BTB predictions fetch->DEC->EX, resolves conditional jumps with same-cycle flush/redirect,
// and queues BTB training updates drained over a valid/ready port; stall freezes the tracking pipe.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PCW   = PC_W
) (
    input logic          clk,
    input logic          rst,
    branch_ctrl_if.slave bus
);
    br_state_e  state_q, state_d;
    pred_rec_t  fetch_rec, dec_q, dec_d, ex_q, ex_d;
    logic [15:0] mcnt_q, mcnt_d;
    logic        is_cond, actual, resolve, mispred, flush;
    logic [PCW-1:0] redirect;
    btb_upd_t    head;
    logic        empty, full;

    assign fetch_rec = '{valid: bus.fetch_valid, pred: bus.btb_prediction, target: bus.btb_target};

    always_comb begin
        actual = 1'b0;
        case (bus.ex_opcode)
            JUMPL:   actual = bus.lflag;
            JUMPG:   actual = bus.gflag;
            JUMPE:   actual = bus.zflag;
            JUMPNE:  actual = ~bus.zflag;
            default: actual = 1'b0;
        endcase
    end

    assign is_cond = is_cond_op(bus.ex_opcode);
    assign resolve = bus.ex_valid & ex_q.valid & ~bus.stall & (state_q == RUN);
    assign mispred = resolve & ((actual != ex_q.pred) ||
                                (actual & ex_q.pred & (bus.ex_target != ex_q.target)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (mispred) state_d = RECOVER;
            RECOVER: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        flush    = 1'b0;
        redirect = '0;
        if (state_q == RUN && mispred) begin
            flush    = 1'b1;
            redirect = actual ? bus.ex_target : bus.ex_pc + PCW'(1);
        end
    end

    // Wrong-path instructions in DEC/EX are killed together with the flush.
    always_comb begin
        dec_d  = dec_q;
        ex_d   = ex_q;
        mcnt_d = mcnt_q;
        if (flush) begin
            dec_d  = '0;
            ex_d   = '0;
            mcnt_d = mcnt_q + 16'd1;
        end else if (!bus.stall) begin
            dec_d = fetch_rec;
            ex_d  = dec_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q  <= '0;
            ex_q   <= '0;
            mcnt_q <= '0;
        end else begin
            dec_q  <= dec_d;
            ex_q   <= ex_d;
            mcnt_q <= mcnt_d;
        end
    end

    btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (resolve & is_cond),
        .push_dat_i ('{pc: bus.ex_pc, target: bus.ex_target, taken: actual}),
        .pop_i      (bus.upd_ready),
        .head_o     (head),
        .empty_o    (empty),
        .full_o     (full),
        .drop_cnt_o (bus.drop_cnt)
    );

    assign bus.flush          = flush;
    assign bus.redirect_pc    = redirect;
    assign bus.upd_valid      = ~empty;
    assign bus.upd_pc         = head.pc;
    assign bus.upd_target     = head.target;
    assign bus.upd_taken      = head.taken;
    assign bus.mispredict_cnt = mcnt_q;

    logic unused_full;
    assign unused_full = full;
endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch-resolution and BTB-update controller between the fetch/decode/execute stages and the 4-way branch target buffer. It tracks each fetched instruction's BTB prediction down the pipe and resolves conditional jumps in execute. On a mispredict it issues a one-cycle flush and a redirect PC. It also queues BTB training updates and drains them to the BTB write port through a valid/ready handshake.

## Interface
- `DEPTH`, default 4: update-queue entries (power of two, ≥2).
- `PCW`, default 16: PC and target width.

- `clk`: in, 1. Single clock; all state updates on posedge.
- `rst`: in, 1. Asynchronous, active-high reset.
- `stall`: in, 1. Hold the decode/execute tracking registers.
- `fetch_valid`: in, 1. Fetch stage holds a real instruction.
- `btb_prediction`: in, 1. BTB taken prediction for the fetch PC.
- `btb_target`: in, PCW. BTB predicted target for the fetch PC.
- `ex_valid`: in, 1. Execute stage holds a real instruction.
- `ex_pc`: in, PCW. Execute instruction PC.
- `ex_opcode`: in, 4. Execute opcode.
- `ex_target`: in, PCW. Computed jump target.
- `lflag`, `gflag`, `zflag`: in, 1 each. Condition flags.
- `flush`: out, 1. Kill fetch/decode contents this cycle.
- `redirect_pc`: out, PCW. Correct next PC; meaningful only while `flush`=1.
- `upd_valid`: out, 1. Queue head is presented to the BTB.
- `upd_ready`: in, 1. BTB accepts the head entry.
- `upd_pc`, `upd_target`: out, PCW. Head entry PC and target.
- `upd_taken`: out, 1. Head entry actual outcome.
- `mispredict_cnt`: out, 16. Wrapping count of mispredicts.
- `drop_cnt`: out, 8. Saturating count of updates dropped because the queue was full.

## Operation
- Tracking pipe: prediction record `{valid, pred, target}` moves from fetch to DEC to EX on each non-stalled cycle. Record valid = `fetch_valid`. On `stall` both records hold.
- Conditional opcodes: JUMPL=0111 (taken=`lflag`), JUMPG=1000 (`gflag`), JUMPE=1001 (`zflag`), JUMPNE=1010 (~`zflag`). Every other opcode has actual taken = 0 and is not queued.
- Resolution applies when `ex_valid` & EX record valid & no stall & state=RUN.
- Mispredict: actual≠pred, or actual=pred=1 with `ex_target`≠record target. A non-branch that was predicted taken is also a mispredict.
- Redirect: actual taken → `ex_target`. Otherwise `ex_pc`+1, wrapping modulo 2^PCW.
- FSM has two states, RUN and RECOVER.
  - RUN → RECOVER on a mispredict. In that cycle: `flush`=1, `redirect_pc` driven, `mispredict_cnt`+1, DEC and EX records cleared at the clock edge.
  - RECOVER → RUN unconditionally after one cycle. In RECOVER: `flush`=0, no resolution, fetch record is captured normally.
- Update queue:
  - Every resolved conditional branch pushes `{ex_pc, ex_target, actual}`, mispredicted or not.
  - Head is shown on `upd_*` with `upd_valid`=~empty. It pops on `upd_valid & upd_ready`.
  - Push and pop in the same cycle while full: both succeed and occupancy is unchanged.
  - Push while full without a pop: entry dropped, `drop_cnt`+1, saturating at 255.
  - Pointers wrap modulo DEPTH.
  - Output fields hold the last head value while empty.

## Timing
- Reset values: `flush`=0, `redirect_pc`=0, `upd_valid`=0, `upd_pc`/`upd_target`=0, `upd_taken`=0, both counters 0. FSM=RUN, records invalid, queue empty.
- Reset is asynchronous. Asserting it mid-recovery or mid-drain discards all state immediately, with no handshake completion.
- `flush`/`redirect_pc` are combinational from the EX record and execute inputs: zero-cycle latency in the resolving cycle, high for exactly one cycle per mispredict.
- A pushed entry appears on `upd_*` at the next posedge, so minimum resolve-to-`upd_valid` latency is 1 cycle.
- `upd_*` must stay stable while `upd_valid`=1 and `upd_ready`=0.
- Counters update at the posedge that ends the triggering cycle.

## Structure
- Shared package `branch_pkg` holds:
  - opcode constants JUMPL/JUMPG/JUMPE/JUMPNE;
  - typedef `pred_rec_t` {valid, pred, target};
  - typedef `btb_upd_t` {pc, target, taken}.
- Sub-module `btb_upd_fifo`: DEPTH-entry synchronous FIFO of `btb_upd_t` with push/pop, full/empty and drop counter.
- Tracking pipe, resolution logic and FSM stay in `branch_ctrl`.

## Test plan
- Correct prediction: fetch pred=1/target=0x0040 reaches EX as JUMPE with `zflag`=1, `ex_target`=0x0040 → `flush`=0; one entry {pc, 0x0040, 1} presented with `upd_valid`=1 next cycle.
- Not-taken mispredict: pred=1, JUMPNE, `zflag`=1, `ex_pc`=0x0010 → `flush`=1 for one cycle, `redirect_pc`=0x0011, `mispredict_cnt`=1, FSM enters RECOVER then returns to RUN.
- Target mismatch: pred=1/target=0x0020, JUMPG with `gflag`=1, `ex_target`=0x0030 → `flush`=1, `redirect_pc`=0x0030. Wrap case: `ex_pc`=0xFFFF mispredicted not-taken → `redirect_pc`=0x0000.
- Queue full: `upd_ready`=0, 6 resolved branches → 4 queued, `drop_cnt`=2. Same cycle push+pop while full → occupancy stays 4, `drop_cnt` unchanged.
- Stall/backpressure: assert `stall` with a branch in EX → no resolution, no flush, records held. Hold `upd_ready`=0 for 3 cycles → `upd_*` stable throughout.
- Async reset asserted during RECOVER with 3 queued entries → all outputs 0 immediately, without waiting for a clock edge; `upd_valid`=0 after release.
